// File: rtl/game_timing_pkg.sv
// Shared timing constants and helpers for the game tick generator.
package game_timing_pkg;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned DEFAULT_DIV = 1_048_576;

  function automatic int unsigned hz_to_div(input int unsigned hz);
    return (hz == 0) ? 0 : CLK_HZ / hz;
  endfunction

  // Difficulty presets for enemy/player movement rates.
  localparam int unsigned DIV_SLOW   = hz_to_div(30);
  localparam int unsigned DIV_NORMAL = hz_to_div(60);
  localparam int unsigned DIV_FAST   = hz_to_div(120);

endpackage

// File: rtl/tick_channel.sv
// One programmable-period tick channel: divisor register, phase counter and
// registered tick. Priority: clr > load > hold > free-running wrap.
module tick_channel #(
  parameter int unsigned         CNT_W   = 24,
  parameter logic [CNT_W-1:0]    RST_DIV = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
  input  logic             hold,
  input  logic             force_tick,
  output logic             tick
);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] eff_m1;

  // A divisor of 0 behaves as 1, so the wrap point is never below 0.
  assign eff_m1 = (div_q == '0) ? '0 : div_q - CNT_W'(1);

  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      div_d = RST_DIV;
      cnt_d = '0;
    end else if (load) begin
      div_d = div_in;
      cnt_d = '0;
    end else if (hold) begin
      tick_d = force_tick;
    end else if (cnt_q == eff_m1) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    div_q  <= div_d;
    cnt_q  <= cnt_d;
    tick_q <= tick_d;
  end

  assign tick = tick_q;

endmodule

// File: rtl/game_tick_generator.sv
// Multi-channel game tick generator with run-time divisors, global pause,
// single-step and a frame counter clocked by channel 0 ticks.
module game_tick_generator #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned DEFAULT_DIV = game_timing_pkg::DEFAULT_DIV,
  parameter int unsigned FRAME_W     = 16,
  parameter int unsigned SEL_W       = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause,
  input  logic               step,
  input  logic               div_load,
  input  logic [SEL_W-1:0]   ch_sel,
  input  logic [CNT_W-1:0]   div_in,
  output logic [NUM_CH-1:0]  tick,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               busy_paused
);

  import game_timing_pkg::*;

  logic [NUM_CH-1:0]  load_vec;
  logic               force_tick;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               busy_paused_q, busy_paused_d;

  // Out-of-range ch_sel never matches, so such loads are dropped.
  always_comb begin
    load_vec = '0;
    for (int i = 0; i < NUM_CH; i++)
      load_vec[i] = div_load && (ch_sel == SEL_W'(i));
  end

  assign force_tick = pause & step;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .CNT_W   (CNT_W),
      .RST_DIV (CNT_W'(DEFAULT_DIV))
    ) u_ch (
      .clk        (clk),
      .clr        (rst),
      .load       (load_vec[g]),
      .div_in     (div_in),
      .hold       (pause),
      .force_tick (force_tick),
      .tick       (tick[g])
    );
  end

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    busy_paused_d = pause;
    if (rst) begin
      frame_cnt_d   = '0;
      busy_paused_d = 1'b0;
    end else if (tick[0]) begin
      frame_cnt_d = frame_cnt_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    frame_cnt_q   <= frame_cnt_d;
    busy_paused_q <= busy_paused_d;
  end

  assign frame_cnt   = frame_cnt_q;
  assign busy_paused = busy_paused_q;

endmodule

// File: doc/game_tick_generator.md
Name: game_tick_generator

Overview:
- Parametrised, multi-channel successor to the single-rate game enable generator.
- Produces NUM_CH independent one-cycle tick enables (for example player movement, enemy movement and animation) from the 50 MHz system clock.
- Each channel's period can be reprogrammed at run time.
- Adds global pause, single-step while paused, and a wrapping frame counter driven by channel 0 for game-logic timing.

Parameters:
- NUM_CH, 3, number of independent tick channels (1..8).
- CNT_W, 24, width of each channel's counter and divisor register.
- DEFAULT_DIV, 1048576, reset divisor loaded into every channel (about 47.7 Hz at 50 MHz).
- FRAME_W, 16, width of the frame counter.
- SEL_W, 3, width of the channel-select bus (must satisfy 2^SEL_W >= NUM_CH).

Ports:
- clk, input, 1, 50 MHz system clock; all logic on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- pause, input, 1, level; while 1, all counters hold and normal ticks are suppressed.
- step, input, 1, single-cycle pulse; while paused, forces one tick on every channel.
- div_load, input, 1, single-cycle pulse; writes div_in into the divisor of channel ch_sel.
- ch_sel, input, SEL_W, target channel for div_load.
- div_in, input, CNT_W, new divisor (period in clk cycles).
- tick, output, NUM_CH, registered one-cycle enable per channel.
- frame_cnt, output, FRAME_W, count of channel-0 ticks; wraps.
- busy_paused, output, 1, registered copy of pause.

Behaviour:
- Reset (rst=1 at a clock edge), applied to every channel:
  - div_reg = DEFAULT_DIV
  - cnt = 0
  - tick = 0
  - frame_cnt = 0
  - busy_paused = 0
  - Reset overrides all other inputs in the same cycle.
- Effective divisor: eff = (div_reg == 0) ? 1 : div_reg. A divisor of 0 behaves as 1, giving a tick every cycle.
- Running (pause=0), per channel:
  - If cnt == eff-1: cnt <= 0 and tick[i] <= 1.
  - Otherwise: cnt <= cnt+1 and tick[i] <= 0.
  - Tick period is exactly eff cycles. The first tick after reset is registered on edge number DEFAULT_DIV, i.e. high during cycle DEFAULT_DIV.
- Paused (pause=1):
  - cnt holds.
  - tick <= 0, except when step=1, in which case tick <= all ones for exactly one cycle and cnt is unchanged.
  - step while pause=0 is ignored.
- Resume:
  - Counting continues from the held cnt; no phase reset.
  - The remaining time to the next tick is preserved.
- Divisor load (div_load=1 and ch_sel < NUM_CH):
  - div_reg[ch_sel] <= div_in and cnt[ch_sel] <= 0.
  - tick[ch_sel] <= 0 that cycle, even if a wrap was due. Load wins over wrap.
  - Other channels are unaffected.
  - Load is accepted while paused; the channel then holds at 0.
  - If ch_sel >= NUM_CH, the load is ignored entirely.
- Step and load together on the same channel: load wins for that channel (no tick); the other channels still step.
- frame_cnt:
  - Increments by 1 in the cycle after tick[0] is high, i.e. it is updated from the registered tick.
  - Wraps from 2^FRAME_W-1 to 0 with no flag.
- busy_paused <= pause each cycle (1-cycle latency).
- Width rules: cnt compare is unsigned at CNT_W bits; no overflow is possible because cnt < eff <= 2^CNT_W-1.
- Output latency: all outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Shared package game_timing_pkg holds:
  - CLK_HZ = 50_000_000
  - DEFAULT_DIV
  - Named divisor constants for each difficulty level: DIV_SLOW, DIV_NORMAL, DIV_FAST
  - A function hz_to_div(hz) that returns CLK_HZ/hz
- One sub-module, tick_channel, contains div_reg, cnt, the wrap compare and tick_reg, with inputs clr, load, div_in, hold, force_tick.
- The top level generates NUM_CH instances of tick_channel and adds the decode, pause/step gating, frame_cnt and busy_paused.

Test Plan (bench overrides DEFAULT_DIV=4, NUM_CH=3):
1. Reset release, no other input -> tick[0..2] high on cycles 4, 8, 12 (period 4); frame_cnt = 1, 2, 3 one cycle after each tick[0].
2. div_load ch_sel=1, div_in=2 at cycle 10 -> channel 1 ticks at cycles 12, 14, 16; channels 0 and 2 are unaffected. div_in=0 on channel 2 -> tick[2] high every cycle.
3. pause=1 at cycle 6 for 5 cycles -> no ticks during the pause; after resume the next tick arrives 2 cycles later (remaining phase preserved); busy_paused follows pause with 1-cycle lag.
4. While paused, step pulse -> tick = 3'b111 for exactly 1 cycle; counters unchanged. The same step with pause=0 produces no extra tick.
5. div_load on ch_sel=0 in the exact cycle its cnt == 3 -> no tick that cycle; next tick[0] arrives div_in cycles later. ch_sel=5 -> no divisor changes.
6. rst=1 mid-period with a load and a step asserted in the same cycle -> all ticks 0, frame_cnt = 0, divisors back to 4. Set frame_cnt near wrap (FRAME_W=4, 16 ticks) -> 15 then 0.
